// File: rtl/alu_seq.sv
// Registered EX-stage ALU with a persistent shift/carry (SC) flag, overflow detect,
// and two multi-cycle operations: iterative shift-add MUL and bit-serial SHN.
module alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             SC_clr,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             SC_out,
  output logic             Ovf,
  output logic [1:0]       dbg_state
);

  // Handshake: Start/OP/InputA/InputB are taken on a rising edge with Busy==0;
  // Done is high for exactly one cycle after the edge that loaded Out/Zero/SC_out/Ovf.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SHN  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_LSH = 4'd1;
  localparam logic [3:0] OP_RSH = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ORR = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_RXR = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_SHN = 4'd10;

  localparam logic [SHAMT_W:0] CNT_MUL_LAST = (SHAMT_W+1)'(WIDTH);

  state_t                 state_q, state_d;
  logic [SHAMT_W:0]       cnt_q, cnt_d;
  logic [SHAMT_W-1:0]     n_q, n_d;
  logic [2*WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic                   done_q, done_d;
  logic [WIDTH-1:0]       out_q, out_d;
  logic                   zero_q, zero_d;
  logic                   sc_q, sc_d;
  logic                   ovf_q, ovf_d;

  logic                   cin;
  logic [SHAMT_W-1:0]     n_in;
  logic [WIDTH:0]         sum_add, sum_adc, diff;
  logic [WIDTH-1:0]       res;
  logic                   res_ovf;
  logic                   sc_upd;
  logic                   sc_val;
  logic [2*WIDTH-1:0]     acc_step;

  assign cin  = SC_clr ? 1'b0 : sc_q;
  assign n_in = InputB[SHAMT_W-1:0];

  assign sum_add  = {1'b0, InputA} + {1'b0, InputB};
  assign sum_adc  = sum_add + {{WIDTH{1'b0}}, cin};
  assign diff     = {1'b0, InputA} - {1'b0, InputB};
  assign acc_step = acc_q + (b_q[0] ? a_q : '0);

  // Single-cycle result, overflow and SC effect for the opcode presented with Start.
  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    sc_upd  = 1'b0;
    sc_val  = 1'b0;
    case (OP)
      OP_ADD: begin
        res     = sum_add[WIDTH-1:0];
        res_ovf = (InputA[WIDTH-1] == InputB[WIDTH-1]) && (res[WIDTH-1] != InputA[WIDTH-1]);
        sc_upd  = 1'b1;
        sc_val  = sum_add[WIDTH];
      end
      OP_LSH: begin
        res    = {InputA[WIDTH-2:0], cin};
        sc_upd = 1'b1;
        sc_val = InputA[WIDTH-1];
      end
      OP_RSH: begin
        res    = {1'b0, InputA[WIDTH-1:1]};
        sc_upd = 1'b1;
        sc_val = InputA[0];
      end
      OP_XOR: res = InputA ^ InputB;
      OP_ORR: res = InputA | InputB;
      OP_SUB: begin
        res     = diff[WIDTH-1:0];
        res_ovf = (InputA[WIDTH-1] != InputB[WIDTH-1]) && (res[WIDTH-1] != InputA[WIDTH-1]);
        sc_upd  = 1'b1;
        sc_val  = diff[WIDTH];
      end
      OP_AND: res = InputA & InputB;
      OP_RXR: res = {{(WIDTH-1){1'b0}}, ^InputA};
      OP_ADC: begin
        res     = sum_adc[WIDTH-1:0];
        res_ovf = (InputA[WIDTH-1] == InputB[WIDTH-1]) && (res[WIDTH-1] != InputA[WIDTH-1]);
        sc_upd  = 1'b1;
        sc_val  = sum_adc[WIDTH];
      end
      OP_SHN: res = InputA;
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    out_d   = out_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    sc_d    = SC_clr ? 1'b0 : sc_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (OP == OP_MUL) begin
            state_d = ST_MUL;
            cnt_d   = {{SHAMT_W{1'b0}}, 1'b1};
            a_d     = {{WIDTH{1'b0}}, InputA};
            b_d     = InputB;
            acc_d   = '0;
          end else if (OP == OP_SHN && n_in != '0) begin
            state_d = ST_SHN;
            cnt_d   = {{SHAMT_W{1'b0}}, 1'b1};
            n_d     = n_in;
            a_d     = {{WIDTH{1'b0}}, InputA};
          end else begin
            done_d = 1'b1;
            out_d  = res;
            zero_d = (res == '0);
            ovf_d  = res_ovf;
            if (sc_upd) sc_d = sc_val;
          end
        end
      end
      ST_MUL: begin
        // One partial product per cycle; the final step's sum is the product.
        acc_d = acc_step;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MUL_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          out_d   = acc_step[WIDTH-1:0];
          zero_d  = (acc_step[WIDTH-1:0] == '0);
          ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
      ST_SHN: begin
        a_d   = a_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {1'b0, n_q}) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          out_d   = {a_q[WIDTH-2:0], 1'b0};
          zero_d  = ({a_q[WIDTH-2:0], 1'b0} == '0);
          ovf_d   = 1'b0;
          sc_d    = a_q[WIDTH-1];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      sc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      sc_q    <= sc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = done_q;
  assign Out       = out_q;
  assign Zero      = zero_q;
  assign SC_out    = sc_q;
  assign Ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): an ordered vector table (SC carries between
// rows) plus hand-written sequences for busy-time Start, SC_clr while busy and reset abort.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         sc_clr;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         zero;
  logic         sc_out;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .OP(op), .InputA(in_a), .InputB(in_b),
    .SC_clr(sc_clr), .Busy(busy), .Done(done), .Out(out), .Zero(zero),
    .SC_out(sc_out), .Ovf(ovf), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr;
    logic [W-1:0] out;
    logic         zero;
    logic         sc;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: present one Start for the edge ending cycle 0
  task automatic start_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic clr);
    start  = 1'b1;
    op     = o;
    in_a   = a;
    in_b   = b;
    sc_clr = clr;
    @(posedge clk);
    #1;
    start  = 1'b0;
    sc_clr = 1'b0;
  endtask

  // scoreboard: wait for Done from cycle cyc0 onwards, compare timing and results
  task automatic wait_done(input string name, input int cyc0, input int lat,
                           input logic [W-1:0] e_out, input logic e_zero,
                           input logic e_sc, input logic e_ovf);
    int cyc;
    logic [W-1:0] e;
    bit seen;
    exp_q.push_back(e_out);
    cyc  = cyc0;
    seen = 1'b0;
    while (cyc <= 40) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      check({name, " busy"}, busy, 1'b1);
      cyc++;
    end
    if (!seen) begin
      check({name, " done timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check({name, " latency"}, cyc, lat);
      check({name, " out"}, out, e);
      check({name, " zero"}, zero, e_zero);
      check({name, " sc"}, sc_out, e_sc);
      check({name, " ovf"}, ovf, e_ovf);
      check({name, " busy at done"}, busy, 1'b0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    start_op(v.op, v.a, v.b, v.clr);
    wait_done(v.name, 1, v.lat, v.out, v.zero, v.sc, v.ovf);
  endtask

  initial begin
    int dones;

    vecs[0]  = '{"add_ff_01",   4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{"adc_01_01",   4'd8,  8'h01, 8'h01, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{"lsh_81",      4'd1,  8'h81, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{"lsh_00",      4'd1,  8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{"sub_80_01",   4'd5,  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1};
    vecs[5]  = '{"sub_01_02",   4'd5,  8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{"xor",         4'd3,  8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1'b1, 1'b0, 1};
    vecs[7]  = '{"orr",         4'd4,  8'h0F, 8'h30, 1'b0, 8'h3F, 1'b0, 1'b1, 1'b0, 1};
    vecs[8]  = '{"and",         4'd6,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b1, 1'b0, 1};
    vecs[9]  = '{"rxr_07",      4'd7,  8'h07, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1};
    vecs[10] = '{"rsh_02",      4'd2,  8'h02, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{"add_7f_01",   4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1};
    vecs[12] = '{"add_ff_02",   4'd0,  8'hFF, 8'h02, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1};
    vecs[13] = '{"reserved_12", 4'd12, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[14] = '{"adc_clr",     4'd8,  8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1};
    vecs[15] = '{"mul_0d_0b",   4'd9,  8'h0D, 8'h0B, 1'b0, 8'h8F, 1'b0, 1'b0, 1'b0, 9};
    vecs[16] = '{"mul_10_10",   4'd9,  8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 9};
    vecs[17] = '{"shn_03_3",    4'd10, 8'h03, 8'h03, 1'b0, 8'h18, 1'b0, 1'b0, 1'b0, 4};
    vecs[18] = '{"shn_03_0",    4'd10, 8'h03, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1};
    vecs[19] = '{"shn_03_7",    4'd10, 8'h03, 8'h07, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 8};
    vecs[20] = '{"adc_ff_00",   4'd8,  8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[21] = '{"mul_ff_ff",   4'd9,  8'hFF, 8'hFF, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 9};
    vecs[22] = '{"shn_01_0b",   4'd10, 8'h01, 8'h0B, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 4};

    reset = 1'b1; start = 1'b0; op = '0; in_a = '0; in_b = '0; sc_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset out", out, 8'h00);
    check("reset zero", zero, 1'b1);
    check("reset sc", sc_out, 1'b0);
    check("reset ovf", ovf, 1'b0);
    check("reset state", dbg_state, 2'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table rows run back-to-back: each Start is driven in the previous Done cycle.
    for (int i = 0; i < 23; i++) run_vec(vecs[i]);
    @(negedge clk);
    check("done single pulse", done, 1'b0);

    // Start during MUL busy is dropped; Out holds its previous value while busy.
    start_op(4'd9, 8'h0D, 8'h0B, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("mul_ign busy", busy, 1'b1);
      check("mul_ign done", done, 1'b0);
      check("mul_ign out held", out, 8'h08);
      if (c == 1) check("mul_ign state", dbg_state, 2'd1);
      if (c == 4) begin
        start = 1'b1; op = 4'd0; in_a = 8'h01; in_b = 8'h01;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    @(negedge clk);
    check("mul_ign done c9", done, 1'b1);
    check("mul_ign out", out, 8'h8F);
    check("mul_ign ovf", ovf, 1'b0);
    @(negedge clk);
    check("mul_ign no queued op", done, 1'b0);
    check("mul_ign idle", busy, 1'b0);

    // SC_clr alone clears SC while a MUL is busy.
    start_op(4'd0, 8'hFF, 8'h01, 1'b0);
    wait_done("sc_set", 1, 1, 8'h00, 1'b1, 1'b1, 1'b0);
    start_op(4'd9, 8'h02, 8'h03, 1'b0);
    @(negedge clk);
    check("clr_busy sc before", sc_out, 1'b1);
    sc_clr = 1'b1;
    @(posedge clk);
    #1 sc_clr = 1'b0;
    @(negedge clk);
    check("clr_busy sc cleared", sc_out, 1'b0);
    check("clr_busy still busy", busy, 1'b1);
    wait_done("clr_busy mul", 3, 9, 8'h06, 1'b0, 1'b0, 1'b0);

    // Reset in cycle 3 of a MUL aborts it without a Done.
    start_op(4'd0, 8'hFF, 8'h02, 1'b0);
    wait_done("pre_reset", 1, 1, 8'h01, 1'b0, 1'b1, 1'b0);
    start_op(4'd9, 8'h0D, 8'h0B, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort out", out, 8'h00);
    check("abort zero", zero, 1'b1);
    check("abort sc", sc_out, 1'b0);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no done", dones, 0);
    start_op(4'd0, 8'h02, 8'h03, 1'b0);
    wait_done("post_reset add", 1, 1, 8'h05, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
